// File: rtl/cpu_pkg.sv
// Shared CPU definitions: controller states, opcodes, bus select codes and widths.
// Imported by the control unit, ALU and instruction register.
package cpu_pkg;

  localparam int unsigned word_size = 8;
  localparam int unsigned opcode_w  = 4;
  localparam int unsigned reg_sel_w = 2;
  localparam int unsigned num_regs  = 4;
  localparam int unsigned sel1_w    = 3;
  localparam int unsigned sel2_w    = 2;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_FET1 = 4'd1,
    S_FET2 = 4'd2,
    S_DEC  = 4'd3,
    S_EX1  = 4'd4,
    S_RD1  = 4'd5,
    S_RD2  = 4'd6,
    S_WR1  = 4'd7,
    S_WR2  = 4'd8,
    S_BR1  = 4'd9,
    S_BR2  = 4'd10,
    S_HALT = 4'd11
  } state_t;

  localparam logic [opcode_w-1:0] OP_NOP = 4'd0;
  localparam logic [opcode_w-1:0] OP_ADD = 4'd1;
  localparam logic [opcode_w-1:0] OP_SUB = 4'd2;
  localparam logic [opcode_w-1:0] OP_AND = 4'd3;
  localparam logic [opcode_w-1:0] OP_NOT = 4'd4;
  localparam logic [opcode_w-1:0] OP_RD  = 4'd5;
  localparam logic [opcode_w-1:0] OP_WR  = 4'd6;
  localparam logic [opcode_w-1:0] OP_BR  = 4'd7;
  localparam logic [opcode_w-1:0] OP_BRZ = 4'd8;

  localparam logic [sel1_w-1:0] SEL1_PC   = 3'd4;
  localparam logic [sel2_w-1:0] SEL2_ALU  = 2'd0;
  localparam logic [sel2_w-1:0] SEL2_BUS1 = 2'd1;
  localparam logic [sel2_w-1:0] SEL2_MEM  = 2'd2;

  // One-hot register-file load strobe for a 2-bit register index.
  function automatic logic [num_regs-1:0] reg_onehot(input logic [reg_sel_w-1:0] idx);
    return num_regs'(1) << idx;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control unit <-> datapath bundle: instruction/flag inputs and all datapath strobes.
interface control_unit_if;
  import cpu_pkg::*;

  logic [word_size-1:0] instruction;
  logic                 zero;
  logic [num_regs-1:0]  load_r;
  logic                 load_pc;
  logic                 inc_pc;
  logic                 load_ir;
  logic                 load_add_r;
  logic                 load_reg_y;
  logic                 load_reg_z;
  logic [sel1_w-1:0]    sel_bus1;
  logic [sel2_w-1:0]    sel_bus2;
  logic                 write;
  logic                 halted;

  modport master (
    input  instruction, zero,
    output load_r, load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z,
           sel_bus1, sel_bus2, write, halted
  );

  modport slave (
    output instruction, zero,
    input  load_r, load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z,
           sel_bus1, sel_bus2, write, halted
  );
endinterface

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit CPU; strobes are decoded
// combinationally from state, instruction and zero flag.
module control_unit
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  control_unit_if.master  cu
);

  state_t state, next_state;

  logic [opcode_w-1:0]  opcode;
  logic [reg_sel_w-1:0] src;
  logic [reg_sel_w-1:0] dest;

  assign opcode = cu.instruction[7:4];
  assign src    = cu.instruction[3:2];
  assign dest   = cu.instruction[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state    = state;
    cu.load_r     = '0;
    cu.load_pc    = 1'b0;
    cu.inc_pc     = 1'b0;
    cu.load_ir    = 1'b0;
    cu.load_add_r = 1'b0;
    cu.load_reg_y = 1'b0;
    cu.load_reg_z = 1'b0;
    cu.sel_bus1   = '0;
    cu.sel_bus2   = '0;
    cu.write      = 1'b0;
    cu.halted     = 1'b0;

    unique case (state)
      S_IDLE: next_state = S_FET1;
      S_FET1: begin
        cu.sel_bus1   = SEL1_PC;
        cu.sel_bus2   = SEL2_BUS1;
        cu.load_add_r = 1'b1;
        cu.inc_pc     = 1'b1;
        next_state    = S_FET2;
      end
      S_FET2: begin
        cu.sel_bus2 = SEL2_MEM;
        cu.load_ir  = 1'b1;
        next_state  = S_DEC;
      end
      S_DEC: begin
        case (opcode)
          OP_NOP: next_state = S_FET1;
          OP_ADD, OP_SUB, OP_AND: begin
            cu.sel_bus1   = sel1_w'(src);
            cu.load_reg_y = 1'b1;
            next_state    = S_EX1;
          end
          OP_NOT: begin
            cu.sel_bus1   = sel1_w'(src);
            cu.sel_bus2   = SEL2_ALU;
            cu.load_reg_z = 1'b1;
            cu.load_r     = reg_onehot(dest);
            next_state    = S_FET1;
          end
          OP_RD, OP_WR, OP_BR, OP_BRZ: begin
            // Untaken BRZ only steps the PC over its address byte.
            if (opcode == OP_BRZ && !cu.zero) begin
              cu.inc_pc  = 1'b1;
              next_state = S_FET1;
            end else begin
              cu.sel_bus1   = SEL1_PC;
              cu.sel_bus2   = SEL2_BUS1;
              cu.load_add_r = 1'b1;
              if      (opcode == OP_RD) next_state = S_RD1;
              else if (opcode == OP_WR) next_state = S_WR1;
              else                      next_state = S_BR1;
            end
          end
          default: next_state = S_HALT;
        endcase
      end
      S_EX1: begin
        cu.sel_bus1   = sel1_w'(dest);
        cu.sel_bus2   = SEL2_ALU;
        cu.load_reg_z = 1'b1;
        cu.load_r     = reg_onehot(dest);
        next_state    = S_FET1;
      end
      S_RD1, S_WR1: begin
        cu.sel_bus2   = SEL2_MEM;
        cu.load_add_r = 1'b1;
        cu.inc_pc     = 1'b1;
        next_state    = (state == S_RD1) ? S_RD2 : S_WR2;
      end
      S_RD2: begin
        cu.sel_bus2 = SEL2_MEM;
        cu.load_r   = reg_onehot(dest);
        next_state  = S_FET1;
      end
      S_WR2: begin
        cu.sel_bus1 = sel1_w'(src);
        cu.write    = 1'b1;
        next_state  = S_FET1;
      end
      S_BR1: begin
        cu.sel_bus2   = SEL2_MEM;
        cu.load_add_r = 1'b1;
        next_state    = S_BR2;
      end
      S_BR2: begin
        cu.sel_bus2 = SEL2_MEM;
        cu.load_pc  = 1'b1;
        next_state  = S_FET1;
      end
      S_HALT: cu.halted = 1'b1;
      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a driver pushes the expected per-cycle
// strobe sequence of each instruction, a negedge monitor pops and compares.
module tb_control_unit;
  import cpu_pkg::*;

  typedef struct packed {
    logic [3:0] load_r;
    logic       load_pc;
    logic       inc_pc;
    logic       load_ir;
    logic       load_add_r;
    logic       load_reg_y;
    logic       load_reg_z;
    logic [2:0] sel_bus1;
    logic [1:0] sel_bus2;
    logic       write;
    logic       halted;
  } vec_t;

  localparam int HALT_CYCLES = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  control_unit_if cu_if ();

  control_unit dut (
    .clk (clk),
    .rst (rst),
    .cu  (cu_if.master)
  );

  always #5 clk = ~clk;

  vec_t        exp_q[$];
  vec_t        seq_q[$];
  bit          mon_en = 1'b0;
  logic [7:0]  cur_ins = 8'h00;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic vec_t read_outs();
    vec_t v;
    v.load_r     = cu_if.load_r;
    v.load_pc    = cu_if.load_pc;
    v.inc_pc     = cu_if.inc_pc;
    v.load_ir    = cu_if.load_ir;
    v.load_add_r = cu_if.load_add_r;
    v.load_reg_y = cu_if.load_reg_y;
    v.load_reg_z = cu_if.load_reg_z;
    v.sel_bus1   = cu_if.sel_bus1;
    v.sel_bus2   = cu_if.sel_bus2;
    v.write      = cu_if.write;
    v.halted     = cu_if.halted;
    return v;
  endfunction

  task automatic chk(input string name, input vec_t act, input vec_t req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  // Reference: an instruction is two fetch cycles, a decode cycle and an
  // opcode-dependent body, each described by the strobes active in it.
  task automatic build(input logic [7:0] ins, input bit z);
    vec_t f1, f2, dec, b1, b2, addr;
    int op, src, dst;
    logic [3:0] dhot;
    op  = int'(ins[7:4]);
    src = int'(ins[3:2]);
    dst = int'(ins[1:0]);
    dhot = 4'b0001 << dst;
    seq_q.delete();
    f1 = '0; f1.sel_bus1 = 3'd4; f1.sel_bus2 = 2'd1; f1.load_add_r = 1; f1.inc_pc = 1;
    f2 = '0; f2.sel_bus2 = 2'd2; f2.load_ir = 1;
    addr = '0; addr.sel_bus1 = 3'd4; addr.sel_bus2 = 2'd1; addr.load_add_r = 1;
    dec = '0; b1 = '0; b2 = '0;
    seq_q.push_back(f1);
    seq_q.push_back(f2);
    case (op)
      0: seq_q.push_back(dec);
      1, 2, 3: begin
        dec.sel_bus1 = 3'(src); dec.load_reg_y = 1;
        b1.sel_bus1 = 3'(dst); b1.sel_bus2 = 2'd0; b1.load_reg_z = 1; b1.load_r = dhot;
        seq_q.push_back(dec); seq_q.push_back(b1);
      end
      4: begin
        dec.sel_bus1 = 3'(src); dec.sel_bus2 = 2'd0; dec.load_reg_z = 1; dec.load_r = dhot;
        seq_q.push_back(dec);
      end
      5, 6: begin
        b1.sel_bus2 = 2'd2; b1.load_add_r = 1; b1.inc_pc = 1;
        if (op == 5) begin b2.sel_bus2 = 2'd2; b2.load_r = dhot; end
        else         begin b2.sel_bus1 = 3'(src); b2.write = 1; end
        seq_q.push_back(addr); seq_q.push_back(b1); seq_q.push_back(b2);
      end
      7, 8: begin
        if (op == 8 && !z) begin
          dec.inc_pc = 1;
          seq_q.push_back(dec);
        end else begin
          b1.sel_bus2 = 2'd2; b1.load_add_r = 1;
          b2.sel_bus2 = 2'd2; b2.load_pc = 1;
          seq_q.push_back(addr); seq_q.push_back(b1); seq_q.push_back(b2);
        end
      end
      default: begin
        seq_q.push_back(dec);
        b1.halted = 1;
        for (int i = 0; i < HALT_CYCLES; i++) seq_q.push_back(b1);
      end
    endcase
  endtask

  // Called at posedge+1 of S_FET1 entry; returns at the next instruction's S_FET1.
  // zero is scrambled every cycle except decode, where the requested value is held.
  task automatic issue(input logic [7:0] ins, input bit z, input int max_cycles, input int req_len);
    int n;
    build(ins, z);
    n = seq_q.size();
    if (req_len > 0) begin
      n_vec++;
      if (n != req_len) begin
        n_err++;
        $display("FAIL cpi ins=%h act=%0d req=%0d", ins, n, req_len);
      end
    end
    if (max_cycles > 0 && max_cycles < n) n = max_cycles;
    for (int k = 0; k < n; k++) exp_q.push_back(seq_q[k]);
    cur_ins = ins;
    cu_if.instruction = ins;
    mon_en = 1'b1;
    for (int k = 0; k < n; k++) begin
      cu_if.zero = (k == 2) ? z : 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin : monitor
    vec_t act, req;
    if (mon_en) begin
      act = read_outs();
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL underrun ins=%h act=%h req=none", cur_ins, act);
      end else begin
        req = exp_q.pop_front();
        if (act !== req) begin
          n_err++;
          $display("FAIL cycle ins=%h act=%h req=%h", cur_ins, act, req);
        end
      end
    end
  end

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] ins;
    vec_t zv;
    zv = '0;
    cu_if.instruction = 8'h00;
    cu_if.zero = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_idle", read_outs(), zv);
    end
    release_reset();

    issue(8'h16, 1'b0, 0, 4);
    issue(8'h53, 1'b0, 0, 5);
    issue(8'h62, 1'b1, 0, 5);
    issue(8'h80, 1'b0, 0, 3);
    issue(8'h80, 1'b1, 0, 5);
    issue(8'h4E, 1'b0, 0, 3);
    issue(8'h00, 1'b1, 0, 3);
    issue(8'h71, 1'b0, 0, 5);

    for (int i = 0; i < 60; i++) begin
      ins = {4'($urandom_range(0, 8)), 4'($urandom)};
      issue(ins, 1'($urandom), 0, 0);
    end

    // Reset during WR1: strobes must drop at once and the write never appears.
    issue(8'h6B, 1'b0, 3, 0);
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("midreset_drop", read_outs(), zv);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midreset_hold", read_outs(), zv);
    end
    release_reset();

    issue(8'hF0, 1'b0, 0, 3 + HALT_CYCLES);
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("halt_async_clear", read_outs(), zv);
    @(negedge clk);
    chk("halt_reset_idle", read_outs(), zv);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover act=%0d req=0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Sequencing state machine for the 8-bit stored-program CPU. Sits directly downstream of the instruction register: consumes the latched instruction word plus the ALU zero flag, and drives every load/select/increment strobe in the datapath, including `load_ir` back to the instruction register. One instruction executes per pass through fetch, decode and execute states. An illegal opcode parks the block in a halt state until reset.

## Interface
- `word_size`, 8: instruction width; opcode is `[7:4]`, src is `[3:2]`, dest is `[1:0]`.
- `clk` in 1: single clock; all state changes occur on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `instruction` in `word_size`: instruction register output.
- `zero` in 1: registered ALU zero flag (Reg_Z).
- `load_r` out 4: one-hot load strobe for register file R0..R3.
- `load_pc`, `inc_pc` out 1: PC parallel load and increment.
- `load_ir`, `load_add_r`, `load_reg_y`, `load_reg_z` out 1: loads for IR, address register, ALU operand Y and zero flag.
- `sel_bus1` out 3: bus-1 source; R0..R3 = 0..3, PC = 4.
- `sel_bus2` out 2: bus-2 source; ALU = 0, bus-1 = 1, memory = 2.
- `write` out 1: memory write enable.
- `halted` out 1: high in S_HALT.

## Operation
- Opcodes: NOP 0, ADD 1, SUB 2, AND 3, NOT 4, RD 5, WR 6, BR 7, BRZ 8. Opcodes 9–15 are illegal.
- Outputs are combinational from the current state, the instruction and `zero`. Any output not listed for a state is 0.
- S_IDLE → S_FET1. No strobes.
- S_FET1: sel_bus1=PC, sel_bus2=bus1, load_add_r, inc_pc. Next state S_FET2.
- S_FET2: sel_bus2=mem, load_ir. Next state S_DEC.
- S_DEC, by opcode:
  - NOP → S_FET1. No strobes.
  - ADD, SUB, AND: sel_bus1=src, load_reg_y. Next state S_EX1.
  - NOT: sel_bus1=src, sel_bus2=ALU, load_reg_z, load_r[dest]. Next state S_FET1.
  - RD, WR, BR: sel_bus1=PC, sel_bus2=bus1, load_add_r. Next state S_RD1, S_WR1 or S_BR1 respectively.
  - BRZ with zero=1: same strobes as BR. Next state S_BR1.
  - BRZ with zero=0: inc_pc only (skips the address byte). Next state S_FET1.
  - Illegal opcode → S_HALT.
- S_EX1: sel_bus1=dest, sel_bus2=ALU, load_reg_z, load_r[dest]. Next state S_FET1.
- S_RD1: sel_bus2=mem, load_add_r, inc_pc. Next state S_RD2.
- S_RD2: sel_bus2=mem, load_r[dest]. Next state S_FET1.
- S_WR1: sel_bus2=mem, load_add_r, inc_pc. Next state S_WR2.
- S_WR2: sel_bus1=src, write. Next state S_FET1.
- S_BR1: sel_bus2=mem, load_add_r. Next state S_BR2.
- S_BR2: sel_bus2=mem, load_pc. Next state S_FET1.
- S_HALT: halted=1. Self-loop; only reset exits.
- `load_r` is never multi-hot. `write` and any `load_r` bit are never asserted in the same cycle.

## Timing
- Reset: state=S_IDLE asynchronously. While rst=0 and in S_IDLE, all outputs are 0.
- On reset release, the first rising edge enters S_FET1.
- `instruction` is sampled only in S_DEC and S_EX1/S_RD2/S_WR2 (src/dest fields). The IR is stable there because it loads at the end of S_FET2.
- Cycles per instruction, counted from S_FET1 entry to the next S_FET1 entry:
  - NOP, NOT, BRZ not taken: 3.
  - ADD, SUB, AND: 4.
  - RD, WR, BR, BRZ taken: 5.
- `zero` is sampled only in S_DEC for BRZ. Changes in other states have no effect.
- Reset asserted mid-instruction: immediate return to S_IDLE, strobes drop in the same cycle, and no partial write completes after reset assertion.

## Structure
- Shared package `cpu_pkg` holds:
  - the 4-bit state encoding for the 12 states;
  - the opcode constants;
  - the bus-1/bus-2 select constants and `word_size`.
- The ALU and instruction register import the same opcode and select constants.
- Single flat module: one state register plus one combinational next-state/output block. No sub-module.

## Test plan
- Hold rst=0 for 3 cycles, then release → all outputs 0 during reset; S_FET1 strobes (sel_bus1=4, load_add_r=1, inc_pc=1) appear one edge after release.
- instruction=8'h16 (ADD R1→R2) → S_DEC: sel_bus1=1, load_reg_y; S_EX1: sel_bus1=2, sel_bus2=0, load_r=4'b0100, load_reg_z; back in S_FET1 after 4 cycles.
- instruction=8'h53 (RD into R3) → S_RD1: inc_pc=1; S_RD2: load_r=4'b1000, sel_bus2=2; 5 cycles total.
- instruction=8'h62 (WR from R0) → S_WR2: write=1, sel_bus1=0, load_r=0.
- instruction=8'h80 with zero=0 → inc_pc in S_DEC, back to S_FET1 after 3 cycles. Repeat with zero=1 → load_pc in S_BR2 after 5 cycles.
- instruction=8'hF0 → S_HALT, halted=1 held for 20 cycles. Then rst=0 → halted=0 asynchronously.
